// File: rtl/lock_pkg.sv
// Shared types and constants for the combination lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    localparam int CC_N  = 0;
    localparam int CC_Z  = 1;
    localparam int CC_B  = 2;
    localparam int CC_C  = 3;
    localparam int CC_VM = 4;
    localparam int CC_VP = 5;

    // Saturating increment of the failed-attempt counter.
    function automatic logic [1:0] sat_inc(input logic [1:0] cnt, input logic [1:0] lim);
        return (cnt >= lim) ? lim : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad, status and external-ALU signals of the lock controller.
interface lock_ctrl_if;
    logic [7:0] digit;
    logic       digit_valid;
    logic       prog;
    logic       relock;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [5:0] alu_cc;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic       busy;

    modport master (
        output digit, digit_valid, prog, relock, alu_cc,
        input  alu_a, alu_b, alu_op, unlocked, alarm, fail_cnt, busy
    );

    modport slave (
        input  digit, digit_valid, prog, relock, alu_cc,
        output alu_a, alu_b, alu_op, unlocked, alarm, fail_cnt, busy
    );
endinterface

// File: rtl/lockout_timer.sv
// Lockout down-counter: loads LOCKOUT_CYCLES-1, counts down while enabled.
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic done
);
    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Down-counter with synchronous load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_W'(0);
        end else if (load) begin
            cnt_r <= CNT_W'(LOCKOUT_CYCLES - 1);
        end else if (enable && (cnt_r != CNT_W'(0))) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_W'(0));
endmodule

// File: rtl/lock_ctrl.sv
// Combination lock controller; digits are compared through an external ALU.
// Optional lockout after MAX_FAILS wrong attempts is built when LOCK_LOCKOUT_EN is defined.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                    CODE_LEN       = 4,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 50_000_000,
    parameter logic [CODE_LEN*8-1:0] DEFAULT_CODE   = {8'd1, 8'd2, 8'd3, 8'd4}
) (
    input  logic        clk,
    input  logic        rst_n,
    lock_ctrl_if.slave  bus
);
    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    lock_state_e                state_r;
    logic [IDX_W-1:0]           idx_r;
    logic                       mismatch_r;
    logic [7:0]                 d_reg_r;
    logic [1:0]                 fail_cnt_r;
    logic [0:CODE_LEN-1][7:0]   code_r;
    logic [0:CODE_LEN-1][7:0]   shadow_r;
    logic [7:0]                 alu_a_r;
    logic [7:0]                 alu_b_r;
    logic                       unlocked_r;
    logic                       busy_r;

    logic                       last_s;
    logic                       miss_s;
    logic [1:0]                 fail_inc_s;
    logic                       to_lockout_s;

`ifdef LOCK_LOCKOUT_EN
    logic alarm_r;
    logic timer_done_s;

    lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (to_lockout_s),
        .enable (state_r == ST_LOCKOUT),
        .done   (timer_done_s)
    );
`endif

    // Attempt evaluation for the current CHECK cycle.
    always_comb begin
        last_s       = (idx_r == IDX_W'(CODE_LEN - 1));
        miss_s       = mismatch_r | ~bus.alu_cc[CC_Z];
        fail_inc_s   = sat_inc(fail_cnt_r, 2'(MAX_FAILS));
`ifdef LOCK_LOCKOUT_EN
        to_lockout_s = (state_r == ST_CHECK) && last_s && miss_s && (fail_inc_s == 2'(MAX_FAILS));
`else
        to_lockout_s = 1'b0;
`endif
    end

    // Main state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LOCKED;
            idx_r      <= IDX_W'(0);
            mismatch_r <= 1'b0;
            d_reg_r    <= 8'd0;
            fail_cnt_r <= 2'd0;
            code_r     <= DEFAULT_CODE;
            shadow_r   <= DEFAULT_CODE;
            alu_a_r    <= 8'd0;
            alu_b_r    <= 8'd0;
            unlocked_r <= 1'b0;
            busy_r     <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
            alarm_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    if (bus.digit_valid) begin
                        d_reg_r <= bus.digit;
                        alu_a_r <= bus.digit;
                        alu_b_r <= code_r[idx_r];
                        busy_r  <= 1'b1;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                ST_CHECK: begin
                    alu_a_r <= 8'd0;
                    alu_b_r <= 8'd0;
                    busy_r  <= 1'b0;
                    if (last_s) begin
                        idx_r      <= IDX_W'(0);
                        mismatch_r <= 1'b0;
                        if (!miss_s) begin
                            fail_cnt_r <= 2'd0;
                            unlocked_r <= 1'b1;
                            state_r    <= ST_OPEN;
                        end else if (to_lockout_s) begin
                            fail_cnt_r <= fail_inc_s;
                            busy_r     <= 1'b1;
`ifdef LOCK_LOCKOUT_EN
                            alarm_r    <= 1'b1;
`endif
                            state_r    <= ST_LOCKOUT;
                        end else begin
                            fail_cnt_r <= fail_inc_s;
                            state_r    <= ST_LOCKED;
                        end
                    end else begin
                        // Mismatch is remembered silently until the last digit.
                        idx_r      <= idx_r + IDX_W'(1);
                        mismatch_r <= miss_s;
                        state_r    <= ST_LOCKED;
                    end
                end
                ST_OPEN: begin
                    if (bus.relock) begin
                        unlocked_r <= 1'b0;
                        state_r    <= ST_LOCKED;
                    end else if (bus.prog) begin
                        idx_r    <= IDX_W'(0);
                        shadow_r <= code_r;
                        state_r  <= ST_PROG;
                    end else begin
                        state_r <= ST_OPEN;
                    end
                end
                ST_PROG: begin
                    if (bus.relock) begin
                        idx_r      <= IDX_W'(0);
                        shadow_r   <= code_r;
                        unlocked_r <= 1'b0;
                        state_r    <= ST_LOCKED;
                    end else if (bus.digit_valid && last_s) begin
                        code_r           <= shadow_r;
                        code_r[idx_r]    <= bus.digit;
                        shadow_r[idx_r]  <= bus.digit;
                        idx_r            <= IDX_W'(0);
                        unlocked_r       <= 1'b0;
                        state_r          <= ST_LOCKED;
                    end else if (bus.digit_valid) begin
                        shadow_r[idx_r] <= bus.digit;
                        idx_r           <= idx_r + IDX_W'(1);
                    end else begin
                        state_r <= ST_PROG;
                    end
                end
                ST_LOCKOUT: begin
`ifdef LOCK_LOCKOUT_EN
                    if (timer_done_s) begin
                        fail_cnt_r <= 2'd0;
                        alarm_r    <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_LOCKED;
                    end else begin
                        state_r <= ST_LOCKOUT;
                    end
`else
                    busy_r  <= 1'b0;
                    state_r <= ST_LOCKED;
`endif
                end
                default: begin
                    state_r <= ST_LOCKED;
                end
            endcase
        end
    end

    assign bus.alu_a    = alu_a_r;
    assign bus.alu_b    = alu_b_r;
    assign bus.alu_op   = ALU_SUB;
    assign bus.unlocked = unlocked_r;
    assign bus.busy     = busy_r;
    assign bus.fail_cnt = fail_cnt_r;
`ifdef LOCK_LOCKOUT_EN
    assign bus.alarm    = alarm_r;
`else
    assign bus.alarm    = 1'b0;
`endif
endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl with a small behavioural ALU.
module tb_lock_ctrl;
    import lock_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [8:0] alu_res_s;

    lock_ctrl_if bus ();

    lock_ctrl #(
        .CODE_LEN       (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model feeding condition codes back to the lock.
    always_comb begin
        alu_res_s = 9'd0;
        case (bus.alu_op)
            ALU_ADD: alu_res_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            ALU_SUB: alu_res_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            ALU_MUL: alu_res_s = {1'b0, 8'(bus.alu_a * bus.alu_b)};
            ALU_AND: alu_res_s = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_res_s = 9'd0;
        endcase
        bus.alu_cc = {1'b0, 1'b0,
                      (bus.alu_op == ALU_ADD) & alu_res_s[8],
                      (bus.alu_op == ALU_SUB) & alu_res_s[8],
                      (alu_res_s[7:0] == 8'd0),
                      alu_res_s[7]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enter_digit(input logic [7:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        tick();
    endtask

    task automatic enter_code(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        enter_digit(d0);
        enter_digit(d1);
        enter_digit(d2);
        enter_digit(d3);
    endtask

    task automatic prog_digit(input logic [7:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic pulse_relock;
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_unlocked"}, 32'(bus.unlocked), 32'd0);
        chk({tag, "_alarm"},    32'(bus.alarm),    32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'd0);
        chk({tag, "_alu_a"},    32'(bus.alu_a),    32'd0);
        chk({tag, "_alu_b"},    32'(bus.alu_b),    32'd0);
        chk({tag, "_alu_op"},   32'(bus.alu_op),   32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.digit       = 8'd0;
        bus.digit_valid = 1'b0;
        bus.prog        = 1'b0;
        bus.relock      = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Correct default code; look inside the first CHECK cycle.
        bus.digit       = 8'd1;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        chk("check_busy",  32'(bus.busy),  32'd1);
        chk("check_alu_a", 32'(bus.alu_a), 32'd1);
        chk("check_alu_b", 32'(bus.alu_b), 32'd1);
        tick();
        chk("post_check_busy",  32'(bus.busy),  32'd0);
        chk("post_check_alu_a", 32'(bus.alu_a), 32'd0);
        enter_digit(8'd2);
        enter_digit(8'd3);
        enter_digit(8'd4);
        chk("open_unlocked", 32'(bus.unlocked), 32'd1);
        chk("open_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        pulse_relock();
        chk("relock_unlocked", 32'(bus.unlocked), 32'd0);

        // Wrong third digit: no early rejection.
        enter_digit(8'd1);
        enter_digit(8'd2);
        enter_digit(8'd9);
        chk("early_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        chk("early_busy",     32'(bus.busy),     32'd0);
        enter_digit(8'd4);
        chk("wrong_unlocked", 32'(bus.unlocked), 32'd0);
        chk("wrong_fail_cnt", 32'(bus.fail_cnt), 32'd1);
        enter_code(8'd1, 8'd2, 8'd3, 8'd4);
        chk("reopen_unlocked", 32'(bus.unlocked), 32'd1);
        chk("reopen_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        pulse_relock();

        // Three wrong attempts.
        enter_code(8'd9, 8'd9, 8'd9, 8'd9);
        chk("fail1_cnt", 32'(bus.fail_cnt), 32'd1);
        enter_code(8'd9, 8'd9, 8'd9, 8'd9);
        chk("fail2_cnt", 32'(bus.fail_cnt), 32'd2);
        enter_code(8'd9, 8'd9, 8'd9, 8'd9);
        chk("fail3_cnt", 32'(bus.fail_cnt), 32'd3);
`ifdef LOCK_LOCKOUT_EN
        for (int i = 0; i < 10; i++) begin
            chk("lockout_alarm", 32'(bus.alarm), 32'd1);
            chk("lockout_busy",  32'(bus.busy),  32'd1);
            bus.digit       = 8'd1;
            bus.digit_valid = (i == 3);
            tick();
        end
        bus.digit_valid = 1'b0;
        chk("lockout_end_alarm", 32'(bus.alarm),    32'd0);
        chk("lockout_end_busy",  32'(bus.busy),     32'd0);
        chk("lockout_end_fail",  32'(bus.fail_cnt), 32'd0);
`else
        chk("nolockout_alarm", 32'(bus.alarm), 32'd0);
        chk("nolockout_busy",  32'(bus.busy),  32'd0);
        enter_code(8'd9, 8'd9, 8'd9, 8'd9);
        chk("fail_saturate", 32'(bus.fail_cnt), 32'd3);
`endif
        enter_code(8'd1, 8'd2, 8'd3, 8'd4);
        chk("after_fails_unlocked", 32'(bus.unlocked), 32'd1);
        chk("after_fails_cnt",      32'(bus.fail_cnt), 32'd0);

        // Reprogram to 7,7,7,7.
        bus.prog = 1'b1;
        tick();
        bus.prog = 1'b0;
        chk("prog_unlocked", 32'(bus.unlocked), 32'd1);
        prog_digit(8'd7);
        prog_digit(8'd7);
        prog_digit(8'd7);
        prog_digit(8'd7);
        chk("prog_done_unlocked", 32'(bus.unlocked), 32'd0);
        enter_code(8'd7, 8'd7, 8'd7, 8'd7);
        chk("new_code_unlocked", 32'(bus.unlocked), 32'd1);
        pulse_relock();
        enter_code(8'd1, 8'd2, 8'd3, 8'd4);
        chk("old_code_unlocked", 32'(bus.unlocked), 32'd0);
        chk("old_code_fail",     32'(bus.fail_cnt), 32'd1);

        // relock beats prog when both are asserted in OPEN.
        enter_code(8'd7, 8'd7, 8'd7, 8'd7);
        bus.prog   = 1'b1;
        bus.relock = 1'b1;
        tick();
        bus.prog   = 1'b0;
        bus.relock = 1'b0;
        chk("relock_wins", 32'(bus.unlocked), 32'd0);

        // Aborted programming leaves the code intact.
        enter_code(8'd7, 8'd7, 8'd7, 8'd7);
        bus.prog = 1'b1;
        tick();
        bus.prog = 1'b0;
        prog_digit(8'd5);
        prog_digit(8'd5);
        pulse_relock();
        chk("abort_unlocked", 32'(bus.unlocked), 32'd0);
        enter_code(8'd7, 8'd7, 8'd7, 8'd7);
        chk("abort_code_kept", 32'(bus.unlocked), 32'd1);
        pulse_relock();

        // Asynchronous reset in the middle of a CHECK.
        enter_code(8'd9, 8'd9, 8'd9, 8'd9);
        chk("pre_rst_fail", 32'(bus.fail_cnt), 32'd1);
        bus.digit       = 8'd9;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
        chk("mid_check_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        enter_code(8'd1, 8'd2, 8'd3, 8'd4);
        chk("rst_default_code", 32'(bus.unlocked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
